// File: rtl/tinker_pkg.sv
// tinker_pkg: shared constants and types for the Tinker fetch front-end
package tinker_pkg;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
    typedef enum logic [1:0] {F_RUN, F_DRAIN, F_HALTED} fetch_state_t;
endpackage

// File: rtl/tinker_fetch_fifo.sv
// tinker_fetch_fifo: in-order buffer of fetched words with flush and registered head
module tinker_fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop, do_push;
    assign head_valid = count != '0;
    assign head = mem[rd_ptr];
    assign do_pop = pop && head_valid;
    assign do_push = push && !flush;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + (do_push ? AW'(1) : AW'(0));
            rd_ptr <= rd_ptr + (do_pop ? AW'(1) : AW'(0));
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/tinker_fetch_unit.sv
// tinker_fetch_unit: sequential instruction fetch with credit-limited issue, redirect flush and halt drain
module tinker_fetch_unit
    import tinker_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt_req,
    output logic        hlt,
    output logic        fetch_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
    fetch_state_t state, state_nx;
    logic [63:0] fetch_pc, rsp_pc;
    logic [CW-1:0] inflight, inflight_nx, drop, count;
    logic fault, req_fire, rsp_ok, halt_go, redir, push, flush, head_valid;
    fetch_entry_t head, rsp_entry;
    assign imem_req_valid = !reset && state == F_RUN && !fault && ({1'b0, inflight} + {1'b0, count}) < CAP;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && inflight != '0;
    assign halt_go        = state == F_RUN && halt_req;
    assign redir          = state == F_RUN && redirect_valid && !halt_req;
    assign push           = rsp_ok && drop == '0 && state == F_RUN && !redir && !halt_go;
    assign flush          = redir || halt_go || state == F_DRAIN;
    assign inflight_nx    = inflight + CW'(req_fire) - CW'(rsp_ok);
    assign rsp_entry      = '{pc: rsp_pc, inst: imem_rsp_data};
    assign inst_valid     = head_valid;
    assign inst_data      = head_valid ? head.inst : '0;
    assign inst_pc        = head_valid ? head.pc : '0;
    assign hlt            = state == F_HALTED;
    assign fetch_fault    = fault;
    always_comb begin
        state_nx = halt_go ? F_DRAIN : (state == F_DRAIN && inflight_nx == '0) ? F_HALTED : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= F_RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= inflight_nx;
            drop     <= (redir || halt_go) ? inflight_nx : drop - CW'(rsp_ok && drop != '0);
            fault    <= fault || (imem_rsp_valid && inflight == '0) || (redir && redirect_pc[1:0] != 2'b00);
            fetch_pc <= redir ? redirect_pc : fetch_pc + (req_fire ? 64'd4 : 64'd0);
            rsp_pc   <= redir ? redirect_pc : rsp_pc + (push ? 64'd4 : 64'd0);
        end
    end
    tinker_fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rsp_entry),
        .pop       (inst_ready),
        .flush     (flush),
        .head      (head),
        .head_valid(head_valid),
        .count     (count)
    );
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// tb_tinker_fetch_unit: directed stimulus against a transaction-level model of the fetch stream
module tb_tinker_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [63:0] RPC = 64'h2000;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;
    logic clk, reset;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [63:0] imem_req_addr, inst_pc, redirect_pc;
    logic [31:0] imem_rsp_data, inst_data;
    logic inst_valid, inst_ready, redirect_valid, halt_req, hlt, fetch_fault;
    int checks = 0, failures = 0;
    tinker_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .hlt(hlt), .fetch_fault(fetch_fault)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    // memory: one response per cycle in request order, the cycle after acceptance, unless held
    logic hold;
    logic [63:0] mq[$];
    logic m_fire;
    logic [63:0] m_addr;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            m_fire = imem_req_valid && imem_req_ready;
            m_addr = imem_req_addr;
            @(posedge clk);
            #1;
            if (m_fire) mq.push_back(m_addr);
            if (!hold && mq.size() != 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = word_at(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = '0;
            end
        end
    end
    // model: outstanding requests tagged live/stale, words owed to decode, fetch stream state
    typedef struct {logic [63:0] a; bit live;} oreq_t;
    oreq_t out_q[$];
    oreq_t e;
    logic [63:0] buf_q[$];
    logic [63:0] seen[$];
    logic [63:0] req_log[$];
    logic [63:0] exp_req;
    int mstate, old;
    bit m_fault, prev_reset, exp_iv, exp_rv, fire, keep;
    always @(negedge clk) begin
        if (reset) begin
            if (prev_reset) begin
                chk("rst_req_valid", imem_req_valid, 0);
                chk("rst_req_addr", imem_req_addr, RPC);
                chk("rst_inst_valid", inst_valid, 0);
                chk("rst_inst_data", inst_data, 0);
                chk("rst_inst_pc", inst_pc, 0);
                chk("rst_hlt", hlt, 0);
                chk("rst_fault", fetch_fault, 0);
            end
            out_q.delete();
            buf_q.delete();
            exp_req = RPC;
            mstate = M_RUN;
            m_fault = 0;
        end else begin
            exp_iv = buf_q.size() > 0;
            exp_rv = mstate == M_RUN && !m_fault && (out_q.size() + buf_q.size()) < DEPTH;
            chk("inst_valid", inst_valid, exp_iv);
            if (exp_iv) begin
                chk("inst_pc", inst_pc, buf_q[0]);
                chk("inst_data", inst_data, word_at(buf_q[0]));
            end
            chk("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
            chk("hlt", hlt, mstate == M_HALTED);
            chk("fetch_fault", fetch_fault, m_fault);
            old = mstate;
            fire = exp_rv && imem_req_ready;
            keep = 0;
            if (imem_rsp_valid) begin
                if (out_q.size() == 0) m_fault = 1;
                else begin
                    e = out_q.pop_front();
                    keep = e.live && old == M_RUN;
                end
            end
            if (exp_iv && inst_ready) begin
                seen.push_back(buf_q[0]);
                void'(buf_q.pop_front());
            end
            if (fire) begin
                req_log.push_back(exp_req);
                out_q.push_back('{a: exp_req, live: 1'b1});
                exp_req = exp_req + 64'd4;
            end
            if (old == M_RUN && (halt_req || redirect_valid)) begin
                foreach (out_q[i]) out_q[i].live = 0;
                buf_q.delete();
                if (halt_req) mstate = M_DRAIN;
                else begin
                    exp_req = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) m_fault = 1;
                end
            end else if (keep) buf_q.push_back(e.a);
            if (old == M_DRAIN && out_q.size() == 0) mstate = M_HALTED;
        end
        prev_reset = reset;
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
    logic [63:0] base;
    initial begin
        reset = 1; imem_req_ready = 1; inst_ready = 1; hold = 0;
        redirect_valid = 0; redirect_pc = '0; halt_req = 0;
        step(3);
        // 1: steady streaming from reset
        reset = 0; req_log.delete(); seen.delete();
        step(12);
        chk("t1_req_count", req_log.size(), 12);
        chk("t1_pop_count", seen.size(), 10);
        if (req_log.size() > 1) begin
            chk("t1_req0", req_log[0], 64'h2000);
            chk("t1_req1", req_log[1], 64'h2004);
        end
        if (seen.size() > 0) chk("t1_pc0", seen[0], 64'h2000);
        // 2: decode stalled -> credit limit
        imem_req_ready = 0; step(4);
        inst_ready = 0; imem_req_ready = 1; req_log.delete();
        step(10);
        chk("t2_req_count", req_log.size(), 4);
        chk("t2_req_valid", imem_req_valid, 0);
        chk("t2_inst_valid", inst_valid, 1);
        base = req_log.size() > 0 ? req_log[0] : '0;
        seen.delete(); inst_ready = 1;
        step(6);
        chk("t2_out_count", seen.size() >= 4, 1);
        for (int i = 0; i < 4; i++) if (i < seen.size()) chk("t2_order", seen[i], base + 64'(4 * i));
        // 3a: redirect with 3 in flight
        imem_req_ready = 0; step(5);
        hold = 1; imem_req_ready = 1; step(3);
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 64'h3000; step(1);
        redirect_valid = 0; hold = 0; imem_req_ready = 1; seen.delete();
        step(8);
        if (seen.size() > 0) chk("t3a_pc0", seen[0], 64'h3000); else chk("t3a_seen", 0, 1);
        // 3b: redirect coincident with a response
        imem_req_ready = 0; step(5);
        hold = 1; imem_req_ready = 1; step(3);
        imem_req_ready = 0; hold = 0; step(1);
        redirect_valid = 1; redirect_pc = 64'h3100; step(1);
        redirect_valid = 0; seen.delete(); imem_req_ready = 1;
        step(8);
        if (seen.size() > 0) chk("t3b_pc0", seen[0], 64'h3100); else chk("t3b_seen", 0, 1);
        // 3c: redirect coincident with a request handshake
        imem_req_ready = 0; step(5);
        hold = 1; imem_req_ready = 1; step(2);
        redirect_valid = 1; redirect_pc = 64'h3200; step(1);
        redirect_valid = 0; hold = 0; req_log.delete(); seen.delete();
        step(8);
        if (req_log.size() > 0) chk("t3c_req0", req_log[0], 64'h3200); else chk("t3c_req", 0, 1);
        if (seen.size() > 0) chk("t3c_pc0", seen[0], 64'h3200); else chk("t3c_seen", 0, 1);
        // 4: misaligned redirect
        redirect_valid = 1; redirect_pc = 64'h3002; step(1);
        redirect_valid = 0; req_log.delete();
        step(6);
        chk("t4_fault", fetch_fault, 1);
        chk("t4_req_valid", imem_req_valid, 0);
        chk("t4_inst_valid", inst_valid, 0);
        chk("t4_req_count", req_log.size(), 0);
        // 5: halt with 2 in flight
        reset = 1; imem_req_ready = 0; step(2);
        reset = 0; hold = 1; imem_req_ready = 1; step(2);
        imem_req_ready = 0; halt_req = 1; step(1);
        halt_req = 0; hold = 0; step(2);
        chk("t5_hlt_early", hlt, 0);
        step(1);
        chk("t5_hlt", hlt, 1);
        imem_req_ready = 1; redirect_valid = 1; redirect_pc = 64'h4000; req_log.delete(); step(1);
        redirect_valid = 0; step(3);
        chk("t5_req_valid", imem_req_valid, 0);
        chk("t5_hlt_sticky", hlt, 1);
        chk("t5_req_count", req_log.size(), 0);
        // 6: reset mid-burst, stale responses afterwards
        reset = 1; imem_req_ready = 0; step(2);
        reset = 0; imem_req_ready = 1; inst_ready = 0; step(2);
        hold = 1; step(2);
        chk("t6_pre_inst_valid", inst_valid, 1);
        reset = 1; imem_req_ready = 0; step(1);
        chk("t6_req_valid", imem_req_valid, 0);
        chk("t6_req_addr", imem_req_addr, 64'h2000);
        chk("t6_inst_valid", inst_valid, 0);
        chk("t6_inst_pc", inst_pc, 0);
        chk("t6_hlt", hlt, 0);
        chk("t6_fault0", fetch_fault, 0);
        reset = 0; hold = 0; step(3);
        chk("t6_fault", fetch_fault, 1);
        chk("t6_req_valid_after", imem_req_valid, 0);
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
